// File: rtl/buffered_simplex_xbar.sv
// Buffered simplex crossbar: NumIn initiators push {index, data} entries into
// one FIFO per target. A round-robin arbiter per target picks one initiator
// per cycle. Each target drains its FIFO with a req/gnt handshake.
module buffered_simplex_xbar #(
   parameter int NumIn     = 4,
   parameter int NumOut    = 4,
   parameter int DataWidth = 32,
   parameter int BufDepth  = 2,
   parameter bit ExtPrio   = 1'b0,
   localparam int IdxW     = (NumIn > 1) ? $clog2(NumIn) : 1,
   localparam int AddW     = (NumOut > 1) ? $clog2(NumOut) : 1,
   localparam int CntW     = $clog2(BufDepth + 1)
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              flush_i,
   input  logic [NumOut-1:0][IdxW-1:0]       rr_i,
   input  logic [NumIn-1:0]                  req_i,
   output logic [NumIn-1:0]                  gnt_o,
   input  logic [NumIn-1:0][AddW-1:0]        add_i,
   input  logic [NumIn-1:0][DataWidth-1:0]   wdata_i,
   output logic [NumOut-1:0]                 req_o,
   input  logic [NumOut-1:0]                 gnt_i,
   output logic [NumOut-1:0][IdxW-1:0]       idx_o,
   output logic [NumOut-1:0][DataWidth-1:0]  wdata_o,
   output logic [NumOut-1:0][CntW-1:0]       usage_o
);

   localparam int PtrW = (BufDepth > 1) ? $clog2(BufDepth) : 1;

   typedef struct packed {
      logic [IdxW-1:0]      idx;
      logic [DataWidth-1:0] data;
   } entry_t;

   // FIFO state per target
   logic [NumOut-1:0][PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [NumOut-1:0][PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [NumOut-1:0][CntW-1:0] usage_q, usage_d;
   // Round-robin start pointer per target (ignored when ExtPrio is set)
   logic [NumOut-1:0][IdxW-1:0] ptr_q, ptr_d;
   entry_t                      mem_q [NumOut][BufDepth];
   entry_t                      mem_d [NumOut][BufDepth];

   // Arbitration results
   logic [NumOut-1:0]           found;
   logic [NumOut-1:0][IdxW-1:0] win;
   logic [NumOut-1:0]           full;
   logic [NumOut-1:0]           push;
   logic [NumOut-1:0]           pop;
   logic [NumIn-1:0]            gnt;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      if (int'(p) == BufDepth - 1) return '0;
      return p + PtrW'(1);
   endfunction

   // Per-target arbiter: first requester at or after the start index wins;
   // a full FIFO, flush or reset suppresses the grant.
   always_comb begin
      int start;
      int j;
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
      found = '0;
      win   = '0;
      full  = '0;
      push  = '0;
      gnt   = '0;
      start = 0;
      j     = 0;
      for (int k = 0; k < NumOut; k++) begin
         // NOTE: blocking assignments here because later statements read these values in the same pass.
         start = ExtPrio ? (int'(rr_i[k]) % NumIn) : int'(ptr_q[k]);
         for (int off = 0; off < NumIn; off++) begin
            j = (start + off) % NumIn;
            // Out-of-range target indices never equal any k, so they are never granted.
            if (!found[k] && req_i[j] && (int'(add_i[j]) == k)) begin
               found[k] = 1'b1;
               win[k]   = IdxW'(j);
            end
         end
         full[k] = (usage_q[k] == CntW'(BufDepth));
         if (found[k] && !full[k] && !flush_i && rst_ni) begin
            push[k]     = 1'b1;
            gnt[win[k]] = 1'b1;
         end
      end
   end

   assign gnt_o = gnt;

   // Pop only a non-empty FIFO; flush overrides the pop.
   always_comb begin
      pop = '0;
      for (int k = 0; k < NumOut; k++) begin
         pop[k] = (usage_q[k] != '0) && gnt_i[k] && !flush_i;
      end
   end

   // FIFO and round-robin next state: flush clears everything, otherwise
   // push at the write pointer and pop at the read pointer independently.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      usage_d  = usage_q;
      ptr_d    = ptr_q;
      mem_d    = mem_q;
      for (int k = 0; k < NumOut; k++) begin
         if (flush_i) begin
            rd_ptr_d[k] = '0;
            wr_ptr_d[k] = '0;
            usage_d[k]  = '0;
            ptr_d[k]    = '0;
         end else begin
            if (push[k]) begin
               mem_d[k][wr_ptr_q[k]] = '{idx: win[k], data: wdata_i[win[k]]};
               wr_ptr_d[k]           = ptr_inc(wr_ptr_q[k]);
               ptr_d[k]              = IdxW'((int'(win[k]) + 1) % NumIn);
            end
            if (pop[k]) begin
               rd_ptr_d[k] = ptr_inc(rd_ptr_q[k]);
            end
            usage_d[k] = usage_q[k] + CntW'(push[k]) - CntW'(pop[k]);
         end
      end
   end

   // Control state register with asynchronous reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         usage_q  <= '0;
         ptr_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         usage_q  <= usage_d;
         ptr_q    <= ptr_d;
      end
   end

   // Entry storage.
   // NOTE: storage is not reset; usage_q gates every read, so stale entries are never visible.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   // Head-of-FIFO outputs, forced to zero while the FIFO is empty.
   always_comb begin
      req_o   = '0;
      idx_o   = '0;
      wdata_o = '0;
      for (int k = 0; k < NumOut; k++) begin
         req_o[k] = (usage_q[k] != '0);
         if (req_o[k]) begin
            idx_o[k]   = mem_q[k][rd_ptr_q[k]].idx;
            wdata_o[k] = mem_q[k][rd_ptr_q[k]].data;
         end
      end
   end

   assign usage_o = usage_q;

endmodule

// File: tb/tb_buffered_simplex_xbar.sv
// Scoreboard bench for buffered_simplex_xbar: a reference model predicts
// grants and queues expected entries per target, and compares them against
// the head outputs every cycle. Directed scenarios add fixed expectations.
module tb_buffered_simplex_xbar;

   localparam int NI = 4;
   localparam int NO = 5;
   localparam int DW = 32;
   localparam int BD = 2;
   localparam int IW = 2;
   localparam int AW = 3;
   localparam int CW = 2;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    flush;
   logic [NO-1:0][IW-1:0]   rr;
   logic [NI-1:0]           req;
   logic [NI-1:0]           gnt;
   logic [NI-1:0]           gnt_e;
   logic [NI-1:0][AW-1:0]   add;
   logic [NI-1:0][DW-1:0]   wdata;
   logic [NO-1:0]           treq, treq_e;
   logic [NO-1:0]           tgnt;
   logic [NO-1:0][IW-1:0]   idx, idx_e;
   logic [NO-1:0][DW-1:0]   tdata, tdata_e;
   logic [NO-1:0][CW-1:0]   usage, usage_e;

   always #5 clk = ~clk;

   buffered_simplex_xbar #(.NumIn(NI), .NumOut(NO), .DataWidth(DW), .BufDepth(BD), .ExtPrio(1'b0)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .rr_i(rr), .req_i(req), .gnt_o(gnt),
      .add_i(add), .wdata_i(wdata), .req_o(treq), .gnt_i(tgnt), .idx_o(idx),
      .wdata_o(tdata), .usage_o(usage));

   buffered_simplex_xbar #(.NumIn(NI), .NumOut(NO), .DataWidth(DW), .BufDepth(BD), .ExtPrio(1'b1)) dut_ep (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .rr_i(rr), .req_i(req), .gnt_o(gnt_e),
      .add_i(add), .wdata_i(wdata), .req_o(treq_e), .gnt_i(tgnt), .idx_o(idx_e),
      .wdata_o(tdata_e), .usage_o(usage_e));

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference model state
   int            sb_idx [NO][$];
   logic [DW-1:0] sb_dat [NO][$];
   int            mptr [NO];
   logic [NI-1:0] exp_gnt;
   logic [NI-1:0] gnt_seen;
   logic [NI-1:0] gnt_e_seen;

   function automatic logic [NI-1:0] model_gnt();
      logic [NI-1:0] g;
      int j;
      g = '0;
      if (flush) return g;
      for (int k = 0; k < NO; k++) begin
         for (int off = 0; off < NI; off++) begin
            j = (mptr[k] + off) % NI;
            if (req[j] && int'(add[j]) == k) begin
               if (sb_idx[k].size() < BD) g[j] = 1'b1;
               break;
            end
         end
      end
      return g;
   endfunction

   task automatic clear_model();
      for (int k = 0; k < NO; k++) begin
         sb_idx[k].delete();
         sb_dat[k].delete();
         mptr[k] = 0;
      end
   endtask

   // One clock cycle: compare at the falling edge, update the model at the rising edge.
   task automatic step();
      @(negedge clk);
      exp_gnt    = model_gnt();
      gnt_seen   = gnt;
      gnt_e_seen = gnt_e;
      check("gnt", gnt, exp_gnt);
      for (int k = 0; k < NO; k++) begin
         check($sformatf("usage%0d", k), usage[k], sb_idx[k].size());
         check($sformatf("req_o%0d", k), treq[k], sb_idx[k].size() != 0);
         check($sformatf("idx%0d", k), idx[k], (sb_idx[k].size() != 0) ? sb_idx[k][0] : 0);
         check($sformatf("data%0d", k), tdata[k], (sb_dat[k].size() != 0) ? sb_dat[k][0] : '0);
      end
      @(posedge clk);
      for (int k = 0; k < NO; k++) begin
         if (flush) begin
            sb_idx[k].delete();
            sb_dat[k].delete();
            mptr[k] = 0;
         end else begin
            if (tgnt[k] && sb_idx[k].size() > 0) begin
               void'(sb_idx[k].pop_front());
               void'(sb_dat[k].pop_front());
            end
            for (int j = 0; j < NI; j++) begin
               if (exp_gnt[j] && int'(add[j]) == k) begin
                  sb_idx[k].push_back(j);
                  sb_dat[k].push_back(wdata[j]);
                  mptr[k] = (j + 1) % NI;
               end
            end
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      req   = '0;
      add   = '0;
      tgnt  = '0;
      flush = 1'b0;
      rr    = '0;
   endtask

   task automatic drain();
      req  = '0;
      tgnt = '1;
      repeat (3) step();
      tgnt = '0;
   endtask

   // Asynchronous reset pulse between clock edges; outputs must clear at once.
   task automatic pulse_reset();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_req_o", treq, '0);
      check("rst_usage", usage, '0);
      check("rst_idx", idx, '0);
      check("rst_data", tdata, '0);
      check("rst_gnt", gnt, '0);
      clear_model();
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      wdata = '0;
      clear_model();
      // Grant must stay low during reset even with a pending request.
      req[0] = 1'b1;
      #3;
      check("reset_gnt", gnt, '0);
      check("reset_usage", usage, '0);
      check("reset_req_o", treq, '0);
      req = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step();

      // Single push from initiator 2 to target 1.
      req[2] = 1'b1; add[2] = 3'd1; wdata[2] = 32'hA5;
      step();
      check("single_gnt", gnt_seen, 4'b0100);
      req = '0;
      check("single_req_o", treq[1], 1'b1);
      check("single_idx", idx[1], 2);
      check("single_data", tdata[1], 32'hA5);
      check("single_usage", usage[1], 1);
      step();
      drain();

      // Contention on target 0 from initiators 0, 1, 3 with continuous pop.
      req = 4'b1011; add = '0; tgnt[0] = 1'b1;
      wdata[0] = 32'h1000; wdata[1] = 32'h1001; wdata[3] = 32'h1003;
      step(); check("rr_gnt0", gnt_seen, 4'b0001);
      step(); check("rr_gnt1", gnt_seen, 4'b0010);
      step(); check("rr_gnt2", gnt_seen, 4'b1000);
      step(); check("rr_gnt3", gnt_seen, 4'b0001);
      drain();

      // Fill target 3, then pop while full: the push must still be blocked.
      req = 4'b0001; add[0] = 3'd3; tgnt = '0;
      wdata[0] = 32'h3000; step(); check("full_gnt0", gnt_seen, 4'b0001);
      wdata[0] = 32'h3001; step(); check("full_gnt1", gnt_seen, 4'b0001);
      wdata[0] = 32'h3002; step(); check("full_gnt2", gnt_seen, 4'b0000);
      check("full_usage", usage[3], 2);
      tgnt[3] = 1'b1;
      step(); check("full_pop_gnt", gnt_seen, 4'b0000);
      check("full_after_pop", usage[3], 1);
      step(); check("full_regnt", gnt_seen, 4'b0001);
      drain();

      // Flush with two entries buffered and a request pending.
      req = 4'b0001; add[0] = 3'd0; tgnt = '0;
      wdata[0] = 32'h5000; step();
      wdata[0] = 32'h5001; step();
      check("flush_pre_usage", usage[0], 2);
      flush = 1'b1;
      step(); check("flush_gnt", gnt_seen, 4'b0000);
      check("flush_usage", usage, '0);
      check("flush_req_o", treq, '0);
      flush = 1'b0; req = '0;
      step();

      // External priority: start at initiator 2; initiators 1 and 3 request target 0.
      rr[0] = 2'd2; req = 4'b1010; add[1] = 3'd0; add[3] = 3'd0;
      wdata[1] = 32'h6001; wdata[3] = 32'h6003;
      step();
      check("ext_prio_gnt", gnt_e_seen, 4'b1000);
      check("int_prio_gnt", gnt_seen, 4'b0010);
      rr = '0;
      drain();

      // Target indices beyond NumOut are never granted.
      req = 4'b0011; add[0] = 3'd5; add[1] = 3'd7;
      step(); check("oob_gnt", gnt_seen, 4'b0000);
      step(); check("oob_usage", usage, '0);
      req = '0;

      // Random traffic with occasional flush and a mid-run reset.
      for (int i = 0; i < 300; i++) begin
         req  = NI'($urandom);
         tgnt = NO'($urandom);
         flush = ($urandom_range(0, 19) == 0);
         for (int j = 0; j < NI; j++) begin
            add[j]   = AW'($urandom_range(0, 5));
            wdata[j] = $urandom;
         end
         if (i == 150) begin
            pulse_reset();
            // First grant after release starts from the cleared state.
            req = 4'b0010; add[1] = 3'd2; wdata[1] = 32'h7777;
            step();
            check("post_rst_gnt", gnt_seen, 4'b0010);
            check("post_rst_usage", usage[2], 1);
            check("post_rst_data", tdata[2], 32'h7777);
         end else begin
            step();
         end
      end
      idle_inputs();
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/buffered_simplex_xbar.md
BUFFERED_SIMPLEX_XBAR -- requirements
Module: buffered_simplex_xbar

Interface
REQ-001 SHALL have parameter NumIn, default 4, number of initiators (>=1).
REQ-002 SHALL have parameter NumOut, default 4, number of targets (>=1).
REQ-003 SHALL have parameter DataWidth, default 32, payload width.
REQ-004 SHALL have parameter BufDepth, default 2, entries per target FIFO (>=1).
REQ-005 SHALL have parameter ExtPrio, default 1'b0, use rr_i as arbiter priority start.
REQ-006 SHALL derive IdxW = max(1, $clog2(NumIn)), AddW = max(1, $clog2(NumOut)), CntW = $clog2(BufDepth+1).
REQ-007 clk_i  input  1  clock; one clock domain.
REQ-008 rst_ni  input  1  reset, asynchronous, active-low.
REQ-009 flush_i  input  1  synchronous clear of all FIFOs.
REQ-010 rr_i  input  NumOut x IdxW  external priority per target.
REQ-011 req_i  input  NumIn  initiator request.
REQ-012 gnt_o  output  NumIn  initiator grant.
REQ-013 add_i  input  NumIn x AddW  target index.
REQ-014 wdata_i  input  NumIn x DataWidth  write data.
REQ-015 req_o  output  NumOut  target request (FIFO non-empty).
REQ-016 gnt_i  input  NumOut  target grant (pop).
REQ-017 idx_o  output  NumOut x IdxW  initiator index of head entry.
REQ-018 wdata_o  output  NumOut x DataWidth  head entry data.
REQ-019 usage_o  output  NumOut x CntW  FIFO occupancy per target.

Function
REQ-020 Per target k, candidates SHALL be initiators j with req_i[j] and add_i[j]==k; add_i[j]>=NumOut SHALL never be granted.
REQ-021 Arbiter k SHALL pick the first candidate at or above start index, wrapping modulo NumIn; start = rr_i[k] if ExtPrio else internal pointer ptr[k].
REQ-022 gnt_o[j] SHALL be 1 in the same cycle only if j wins arbiter add_i[j], that FIFO is not full, and flush_i==0; at most one grant per target per cycle.
REQ-023 On grant, {j, wdata_i[j]} SHALL be written into FIFO k at the next rising edge.
REQ-024 ptr[k] SHALL update to (winner+1) mod NumIn on each grant to k, else hold; unused when ExtPrio=1.
REQ-025 Full FIFO SHALL block pushes even if gnt_i[k]=1 that cycle; no combinational path gnt_i->gnt_o.
REQ-026 No fall-through: entry pushed at edge N SHALL appear at req_o/idx_o/wdata_o after edge N (latency 1 cycle).
REQ-027 req_o[k]=1 iff usage_o[k]!=0; idx_o/wdata_o SHALL show the oldest entry, held stable while req_o[k]=1 and gnt_i[k]=0.
REQ-028 req_o[k]&gnt_i[k] SHALL pop the head at the next edge; gnt_i with empty FIFO SHALL be ignored.
REQ-029 Simultaneous push and pop on a non-full FIFO SHALL leave usage unchanged and preserve order.
REQ-030 Read/write pointers SHALL wrap modulo BufDepth; usage SHALL never exceed BufDepth or go below 0.
REQ-031 flush_i=1 SHALL force gnt_o=0 and at next edge set all usage to 0 and ptr to 0; flush overrides push and pop.
REQ-032 NumIn==1: no arbitration, idx_o=0; candidate is initiator 0.
REQ-033 idx_o/wdata_o SHALL be 0 when req_o[k]=0.

Reset
REQ-034 rst_ni low SHALL asynchronously clear all FIFO pointers, usage_o=0, ptr=0, req_o=0, idx_o=0, wdata_o=0; gnt_o=0 during reset.
REQ-035 Reset asserted mid-operation SHALL discard all buffered entries; first grant after release follows REQ-022 from cleared state.

Verification
REQ-036 Single push: req_i[2]=1, add_i[2]=1, wdata 0xA5 -> gnt_o[2]=1 same cycle; next cycle req_o[1]=1, idx_o[1]=2, wdata_o[1]=0xA5, usage_o[1]=1.
REQ-037 Contention, ExtPrio=0: initiators 0,1,3 hold req to target 0, gnt_i[0]=1 -> grant order 0,1,3,0,...; one grant per cycle.
REQ-038 Full: BufDepth=2, gnt_i[3]=0, initiator 0 to target 3 three cycles -> gnt_o[0]=1,1,0; usage_o[3]=2; pop while full still gives gnt_o[0]=0 that cycle.
REQ-039 ExtPrio=1, rr_i[0]=2, initiators 1 and 3 request target 0 -> initiator 3 granted.
REQ-040 Flush with usage_o[0]=2 and pending req -> gnt_o=0 that cycle; next cycle usage_o=0, req_o=0; rst_ni pulse mid-traffic -> same cleared state immediately.
REQ-041 add_i=5 with NumOut=5 -> gnt_o stays 0, no FIFO changes.
